store_align_unit: RTL and testbench
===================================

// Module: store_align_unit
// PURPOSE
//   Store-side counterpart of the MEM/WB load extension path: aligns SB/SH/SW store
//   data into word-wide memory writes and generates per-byte write strobes.
//   Sits in MEM stage between the EX/MEM register and the data-memory write port.
//   Stores crossing a word boundary are split into two sequential word writes.
//   The pipeline is stalled while a store is in flight.
// PARAMETERS
//   ADDR_W    32  byte-address width of st_addr / mem_addr
//   SPLIT_EN  1   1: split word-crossing stores into 2 beats; 0: drop them, flag misalign_err
// PORTS
//   clk           in   1       clock, all state on rising edge
//   reset         in   1       asynchronous, active-low reset
//   st_valid      in   1       store request from EX/MEM
//   st_funct3     in   3       0=SB 1=SH 2=SW; others illegal
//   st_addr       in   ADDR_W  byte address
//   st_data       in   32      rs2 value, right-justified
//   st_ready      out  1       unit idle, request accepted when st_valid&&st_ready
//   stall         out  1       hold upstream pipeline stages
//   mem_req       out  1       write request to data memory
//   mem_addr      out  ADDR_W  word-aligned address ([1:0]=0)
//   mem_wdata     out  32      lane-aligned write data
//   mem_wstrb     out  4       byte write enables, bit i -> mem_wdata[8i+7:8i]
//   mem_ack       in   1       memory accepted current beat
//   misalign_err  out  1       1-cycle pulse, crossing store dropped (SPLIT_EN=0)
// BEHAVIOUR
//   Reset (reset=0, async): state IDLE; mem_req=0, mem_addr=0, mem_wdata=0,
//     mem_wstrb=0, misalign_err=0; st_ready=1, stall=0. Takes effect immediately,
//     aborting any beat in flight; no beat is resumed after release.
//   FSM: IDLE -> BEAT0 -> (BEAT1) -> IDLE. st_ready = (state==IDLE); stall = !st_ready.
//   Accept (IDLE, st_valid=1): off=st_addr[1:0]; mask=1/3/F for SB/SH/SW;
//     sdat[63:0] = {32'b0,st_data} << 8*off; sstb[7:0] = {4'b0,mask} << off.
//     Size-masked: bytes above store size are zero before shifting.
//   Beat0 (registered, cycle after accept): mem_req=1, mem_addr={st_addr[ADDR_W-1:2],2'b0},
//     mem_wdata=sdat[31:0], mem_wstrb=sstb[3:0].
//   Crossing store: sstb[7:4]!=0. Beat1 address = beat0 address + 4, mod 2^ADDR_W
//     (wraps); mem_wdata=sdat[63:32], mem_wstrb=sstb[7:4].
//   Handshake: while mem_req && !mem_ack, mem_addr/wdata/wstrb held stable.
//     mem_ack in BEAT0: crossing -> BEAT1, next beat driven next cycle, mem_req stays 1;
//     else -> IDLE, mem_req=0 next cycle. mem_ack in BEAT1 -> IDLE.
//     mem_ack while mem_req=0 is ignored.
//   Back-to-back: st_ready rises the cycle after the final ack; min 2 cycles/aligned store.
//   Illegal funct3 (3..7): accepted, dropped; no mem_req, no error, stays IDLE.
//   SPLIT_EN=0 and crossing: accepted, no mem_req, misalign_err=1 for exactly the
//     next cycle, stays IDLE.
//   Beat0 with sstb[3:0]=0 cannot occur (off<4 and mask!=0).
// TESTING
//   SB addr 0x1003 data 0xAABBCCDD -> 1 beat: addr 0x1000, wstrb 4'b1000, wdata 0xDD000000
//   SH addr 0x2002 data 0x00001234 -> 1 beat: addr 0x2000, wstrb 4'b1100, wdata 0x12340000
//   SW addr 0x3003 data 0x11223344 -> beat0 0x3000/4'b1000/0x44000000; beat1 0x3004/4'b0111/0x00112233
//   mem_ack low 5 cycles on SW 0xFFFFFFFE -> beat0 held stable, stall=1 throughout;
//     beat1 addr 0x00000000, wstrb 4'b0011
//   reset=0 during BEAT1 -> mem_req=0 same cycle; after release st_ready=1, no further beats
//   SPLIT_EN=0, SH addr 0x4003 -> no mem_req; misalign_err high exactly 1 cycle; st_ready stays 1

Source files
------------

// File: rtl/store_align_unit_if.sv
// Store request / data-memory write bundle for store_align_unit.
// The unit connects through the slave modport; the upstream stage and memory side use master.
interface store_align_unit_if #(
  parameter int ADDR_W = 32
);
  logic              st_valid;
  logic [2:0]        st_funct3;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_data;
  logic              st_ready;
  logic              stall;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ack;
  logic              misalign_err;

  // Store side: request accepted when st_valid && st_ready.
  // Memory side: a beat completes when mem_req && mem_ack; addr/wdata/wstrb hold until then.
  modport slave (
    input  st_valid, st_funct3, st_addr, st_data, mem_ack,
    output st_ready, stall, mem_req, mem_addr, mem_wdata, mem_wstrb, misalign_err
  );

  modport master (
    output st_valid, st_funct3, st_addr, st_data, mem_ack,
    input  st_ready, stall, mem_req, mem_addr, mem_wdata, mem_wstrb, misalign_err
  );
endinterface

// File: rtl/store_align_unit.sv
// MEM-stage store aligner: turns SB/SH/SW into lane-aligned word writes with byte strobes,
// splitting word-crossing stores into two beats (or dropping them when SPLIT_EN=0).
module store_align_unit #(
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  store_align_unit_if.slave    bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       hi_data_q, hi_data_d;
  logic [3:0]        hi_stb_q, hi_stb_d;
  logic              cross_q, cross_d;
  logic              err_q, err_d;

  logic [1:0]  off;
  logic [3:0]  mask;
  logic [31:0] sized;
  logic        legal;
  logic [63:0] sdat;
  logic [7:0]  sstb;
  logic        crossing;

  // Size-mask first so bytes above the store width never reach the lanes.
  always_comb begin
    off   = bus.st_addr[1:0];
    legal = 1'b1;
    mask  = 4'hF;
    sized = bus.st_data;
    case (bus.st_funct3)
      3'd0: begin
        mask  = 4'h1;
        sized = {24'b0, bus.st_data[7:0]};
      end
      3'd1: begin
        mask  = 4'h3;
        sized = {16'b0, bus.st_data[15:0]};
      end
      3'd2: begin
        mask  = 4'hF;
        sized = bus.st_data;
      end
      default: begin
        legal = 1'b0;
        mask  = 4'h0;
        sized = 32'b0;
      end
    endcase
    sdat     = {32'b0, sized} << {off, 3'b000};
    sstb     = {4'b0, mask} << off;
    crossing = |sstb[7:4];
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    hi_data_d = hi_data_q;
    hi_stb_d  = hi_stb_q;
    cross_d   = cross_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.st_valid && legal) begin
          if (crossing && !SPLIT_EN) begin
            err_d = 1'b1;
          end else begin
            state_d   = BEAT0;
            addr_d    = {bus.st_addr[ADDR_W-1:2], 2'b00};
            wdata_d   = sdat[31:0];
            wstrb_d   = sstb[3:0];
            hi_data_d = sdat[63:32];
            hi_stb_d  = sstb[7:4];
            cross_d   = crossing;
          end
        end
      end
      BEAT0: begin
        if (bus.mem_ack) begin
          if (cross_q) begin
            state_d = BEAT1;
            addr_d  = addr_q + ADDR_W'(4);
            wdata_d = hi_data_q;
            wstrb_d = hi_stb_q;
          end else begin
            state_d = IDLE;
            addr_d  = '0;
            wdata_d = 32'b0;
            wstrb_d = 4'b0;
          end
        end
      end
      BEAT1: begin
        if (bus.mem_ack) begin
          state_d = IDLE;
          addr_d  = '0;
          wdata_d = 32'b0;
          wstrb_d = 4'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= 32'b0;
      wstrb_q   <= 4'b0;
      hi_data_q <= 32'b0;
      hi_stb_q  <= 4'b0;
      cross_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      hi_data_q <= hi_data_d;
      hi_stb_q  <= hi_stb_d;
      cross_q   <= cross_d;
      err_q     <= err_d;
    end
  end

  // mem_req follows the state register so an async reset drops it immediately.
  assign bus.st_ready     = (state_q == IDLE);
  assign bus.stall        = (state_q != IDLE);
  assign bus.mem_req      = (state_q != IDLE);
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_wstrb    = wstrb_q;
  assign bus.misalign_err = err_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit: vector table of single/split stores plus
// hand sequences for back-pressure, reset mid-beat, illegal funct3 and SPLIT_EN=0.
module tb_store_align_unit;

  logic clk;
  logic reset;
  logic [1:0] dbg1, dbg2;

  store_align_unit_if #(.ADDR_W(32)) bus1 ();
  store_align_unit_if #(.ADDR_W(32)) bus2 ();

  store_align_unit #(.ADDR_W(32), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus1), .dbg_state_o(dbg1)
  );
  store_align_unit #(.ADDR_W(32), .SPLIT_EN(1'b0)) dut_nosplit (
    .clk(clk), .reset(reset), .bus(bus2), .dbg_state_o(dbg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    int          nbeats;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [3:0]  s0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [3:0]  s1;
  } vec_t;

  vec_t vecs[7];

  task automatic issue1(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus1.st_funct3 = f3;
    bus1.st_addr   = addr;
    bus1.st_data   = data;
    bus1.st_valid  = 1'b1;
    @(posedge clk);
    #1 bus1.st_valid = 1'b0;
  endtask

  task automatic ack_beat1;
    bus1.mem_ack = 1'b1;
    @(posedge clk);
    #1 bus1.mem_ack = 1'b0;
  endtask

  task automatic check_beat(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    check({tag, ".req"},   {31'b0, bus1.mem_req}, 32'd1);
    check({tag, ".stall"}, {31'b0, bus1.stall}, 32'd1);
    check({tag, ".ready"}, {31'b0, bus1.st_ready}, 32'd0);
    check({tag, ".addr"},  bus1.mem_addr, a);
    check({tag, ".wdata"}, bus1.mem_wdata, d);
    check({tag, ".wstrb"}, {28'b0, bus1.mem_wstrb}, {28'b0, s});
    check({tag, ".err"},   {31'b0, bus1.misalign_err}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{3'd0, 32'h0000_1003, 32'hAABB_CCDD, 1, 32'h0000_1000, 32'hDD00_0000, 4'b1000, 32'h0, 32'h0, 4'b0};
    vecs[1] = '{3'd1, 32'h0000_2002, 32'h0000_1234, 1, 32'h0000_2000, 32'h1234_0000, 4'b1100, 32'h0, 32'h0, 4'b0};
    vecs[2] = '{3'd2, 32'h0000_3003, 32'h1122_3344, 2, 32'h0000_3000, 32'h4400_0000, 4'b1000, 32'h0000_3004, 32'h0011_2233, 4'b0111};
    vecs[3] = '{3'd2, 32'h0000_4000, 32'hDEAD_BEEF, 1, 32'h0000_4000, 32'hDEAD_BEEF, 4'b1111, 32'h0, 32'h0, 4'b0};
    vecs[4] = '{3'd1, 32'h0000_5001, 32'hFFFF_5678, 1, 32'h0000_5000, 32'h0056_7800, 4'b0110, 32'h0, 32'h0, 4'b0};
    vecs[5] = '{3'd1, 32'h0000_6003, 32'h0000_ABCD, 2, 32'h0000_6000, 32'hCD00_0000, 4'b1000, 32'h0000_6004, 32'h0000_00AB, 4'b0001};
    vecs[6] = '{3'd0, 32'h0000_7000, 32'h1234_5678, 1, 32'h0000_7000, 32'h0000_0078, 4'b0001, 32'h0, 32'h0, 4'b0};

    reset = 1'b0;
    bus1.st_valid = 1'b0; bus1.st_funct3 = 3'd0; bus1.st_addr = 32'h0; bus1.st_data = 32'h0; bus1.mem_ack = 1'b0;
    bus2.st_valid = 1'b0; bus2.st_funct3 = 3'd0; bus2.st_addr = 32'h0; bus2.st_data = 32'h0; bus2.mem_ack = 1'b0;
    repeat (3) @(posedge clk);

    // Reset state
    @(negedge clk);
    check("rst.req",   {31'b0, bus1.mem_req}, 32'd0);
    check("rst.addr",  bus1.mem_addr, 32'd0);
    check("rst.wdata", bus1.mem_wdata, 32'd0);
    check("rst.wstrb", {28'b0, bus1.mem_wstrb}, 32'd0);
    check("rst.err",   {31'b0, bus1.misalign_err}, 32'd0);
    check("rst.ready", {31'b0, bus1.st_ready}, 32'd1);
    check("rst.stall", {31'b0, bus1.stall}, 32'd0);
    check("rst.state", {30'b0, dbg1}, 32'd0);
    reset = 1'b1;

    // Table-driven stores, each acked immediately
    for (int i = 0; i < 7; i++) begin
      issue1(vecs[i].f3, vecs[i].addr, vecs[i].data);
      @(negedge clk);
      check_beat($sformatf("v%0d.b0", i), vecs[i].a0, vecs[i].d0, vecs[i].s0);
      ack_beat1();
      if (vecs[i].nbeats == 2) begin
        @(negedge clk);
        check_beat($sformatf("v%0d.b1", i), vecs[i].a1, vecs[i].d1, vecs[i].s1);
        ack_beat1();
      end
      @(negedge clk);
      check($sformatf("v%0d.done_req", i),   {31'b0, bus1.mem_req}, 32'd0);
      check($sformatf("v%0d.done_ready", i), {31'b0, bus1.st_ready}, 32'd1);
    end

    // Back-pressure on a wrapping SW: beat0 held for 5 cycles
    issue1(3'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_beat($sformatf("hold%0d", c), 32'hFFFF_FFFC, 32'hF00D_0000, 4'b1100);
    end
    ack_beat1();
    @(negedge clk);
    check_beat("wrap.b1", 32'h0000_0000, 32'h0000_CAFE, 4'b0011);
    ack_beat1();
    @(negedge clk);
    check("wrap.done", {31'b0, bus1.mem_req}, 32'd0);

    // Reset asserted in the middle of BEAT1
    issue1(3'd2, 32'h0000_3003, 32'h1122_3344);
    @(negedge clk);
    ack_beat1();
    @(negedge clk);
    check("rb1.state", {30'b0, dbg1}, 32'd2);
    check("rb1.req",   {31'b0, bus1.mem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("rb1.req_now",   {31'b0, bus1.mem_req}, 32'd0);
    check("rb1.ready_now", {31'b0, bus1.st_ready}, 32'd1);
    check("rb1.wstrb_now", {28'b0, bus1.mem_wstrb}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rb1.post%0d.req", c),   {31'b0, bus1.mem_req}, 32'd0);
      check($sformatf("rb1.post%0d.ready", c), {31'b0, bus1.st_ready}, 32'd1);
    end

    // Illegal funct3 is swallowed
    issue1(3'd3, 32'h0000_8000, 32'h1234_5678);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("ill%0d.req", c),   {31'b0, bus1.mem_req}, 32'd0);
      check($sformatf("ill%0d.ready", c), {31'b0, bus1.st_ready}, 32'd1);
      check($sformatf("ill%0d.err", c),   {31'b0, bus1.misalign_err}, 32'd0);
    end

    // SPLIT_EN=0: crossing SH dropped with a one-cycle error pulse
    @(negedge clk);
    bus2.st_funct3 = 3'd1; bus2.st_addr = 32'h0000_4003; bus2.st_data = 32'h0000_BEEF; bus2.st_valid = 1'b1;
    @(posedge clk);
    #1 bus2.st_valid = 1'b0;
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("ns%0d.err", c),   {31'b0, bus2.misalign_err}, exp_q.pop_front());
      check($sformatf("ns%0d.req", c),   {31'b0, bus2.mem_req}, 32'd0);
      check($sformatf("ns%0d.ready", c), {31'b0, bus2.st_ready}, 32'd1);
    end

    // SPLIT_EN=0: an aligned SW still writes normally
    @(negedge clk);
    bus2.st_funct3 = 3'd2; bus2.st_addr = 32'h0000_9000; bus2.st_data = 32'h0BAD_F00D; bus2.st_valid = 1'b1;
    @(posedge clk);
    #1 bus2.st_valid = 1'b0;
    @(negedge clk);
    check("ns_sw.req",   {31'b0, bus2.mem_req}, 32'd1);
    check("ns_sw.addr",  bus2.mem_addr, 32'h0000_9000);
    check("ns_sw.wdata", bus2.mem_wdata, 32'h0BAD_F00D);
    check("ns_sw.wstrb", {28'b0, bus2.mem_wstrb}, 32'h0000_000F);
    check("ns_sw.err",   {31'b0, bus2.misalign_err}, 32'd0);
    bus2.mem_ack = 1'b1;
    @(posedge clk);
    #1 bus2.mem_ack = 1'b0;
    @(negedge clk);
    check("ns_sw.done", {31'b0, bus2.mem_req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
